axi4_id_resp_demux: RTL and testbench

- Sits directly upstream of the per-ID response-queue checker on the AXI4 master port.
- Takes the R (read data) and B (write response) channels from the bus.
- Steers each beat by its 4-bit ID into one of NUM_IDS small per-ID FIFOs per channel.
- Exports per-queue enqueue-ready bits for the downstream checker, and sinks and flags beats carrying an unsupported ID.

---
 rtl/axi4_id_resp_demux_if.sv | 41 ++++
 rtl/axi4_id_resp_demux.sv | 144 ++++++++++++++
 tb/tb_axi4_id_resp_demux.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_id_resp_demux_if.sv
// R/B channel, per-ID dequeue and error-report signals for axi4_id_resp_demux.
interface axi4_id_resp_demux_if #(
    parameter int unsigned NUM_IDS = 2,
    parameter int unsigned DATA_W  = 64
);
    logic                            r_valid;
    logic                            r_ready;
    logic [3:0]                      r_id;
    logic [DATA_W-1:0]               r_data;
    logic                            r_last;
    logic                            b_valid;
    logic                            b_ready;
    logic [3:0]                      b_id;
    logic [1:0]                      b_resp;
    logic [NUM_IDS-1:0]              r_q_ready;
    logic [NUM_IDS-1:0]              b_q_ready;
    logic [NUM_IDS-1:0]              r_deq_valid;
    logic [NUM_IDS-1:0]              r_deq_ready;
    logic [NUM_IDS*(DATA_W+1)-1:0]   r_deq_data;
    logic [NUM_IDS-1:0]              b_deq_valid;
    logic [NUM_IDS-1:0]              b_deq_ready;
    logic [NUM_IDS*2-1:0]            b_deq_resp;
    logic                            err_valid;
    logic                            err_chan;
    logic [3:0]                      err_id;
    logic                            err_clear;

    modport slave (
        input  r_valid, r_id, r_data, r_last, b_valid, b_id, b_resp,
               r_deq_ready, b_deq_ready, err_clear,
        output r_ready, b_ready, r_q_ready, b_q_ready, r_deq_valid, r_deq_data,
               b_deq_valid, b_deq_resp, err_valid, err_chan, err_id
    );

    modport master (
        output r_valid, r_id, r_data, r_last, b_valid, b_id, b_resp,
               r_deq_ready, b_deq_ready, err_clear,
        input  r_ready, b_ready, r_q_ready, b_q_ready, r_deq_valid, r_deq_data,
               b_deq_valid, b_deq_resp, err_valid, err_chan, err_id
    );
endinterface

// File: rtl/axi4_id_resp_demux.sv
// Steers AXI4 R/B beats by ID into per-ID FIFOs; sinks and flags illegal IDs.
module axi4_id_resp_demux_q #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         enq,
    input  logic [W-1:0] enq_data,
    input  logic         deq_ready,
    output logic         deq_valid,
    output logic         not_full,
    output logic [W-1:0] deq_data
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] cnt;
    logic [W-1:0]  mem [DEPTH];
    logic          wr;
    logic          rd;

    // Flags derive from registered count only; no path from deq_ready.
    assign deq_valid = (cnt != '0);
    assign not_full  = (cnt != CW'(DEPTH));
    assign wr        = enq & not_full;
    assign rd        = deq_valid & deq_ready;
    assign deq_data  = mem[rptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (wr) wptr <= wptr + 1'b1;
            if (rd) rptr <= rptr + 1'b1;
            if (wr && !rd)      cnt <= cnt + 1'b1;
            else if (!wr && rd) cnt <= cnt - 1'b1;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clock) begin
        if (wr) mem[wptr] <= enq_data;
    end
endmodule

module axi4_id_resp_demux #(
    parameter int unsigned NUM_IDS = 2,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned DATA_W  = 64
) (
    input logic                  clock,
    input logic                  reset_n,
    axi4_id_resp_demux_if.slave  bus
);
    localparam int unsigned RW = DATA_W + 1;

    logic [NUM_IDS-1:0] r_q_rdy;
    logic [NUM_IDS-1:0] b_q_rdy;
    logic [15:0]        r_rdy_pad;
    logic [15:0]        b_rdy_pad;
    logic               r_ready;
    logic               b_ready;
    logic               r_legal;
    logic               b_legal;
    logic               r_err;
    logic               b_err;
    logic               err_valid;
    logic               err_chan;
    logic [3:0]         err_id;

    // Unused ID slots read as ready so illegal beats are always sunk.
    always_comb begin
        r_rdy_pad                = '1;
        b_rdy_pad                = '1;
        r_rdy_pad[NUM_IDS-1:0]   = r_q_rdy;
        b_rdy_pad[NUM_IDS-1:0]   = b_q_rdy;
    end

    assign r_ready = r_rdy_pad[bus.r_id];
    assign b_ready = b_rdy_pad[bus.b_id];
    assign r_legal = ({1'b0, bus.r_id} < 5'(NUM_IDS));
    assign b_legal = ({1'b0, bus.b_id} < 5'(NUM_IDS));
    assign r_err   = bus.r_valid & ~r_legal;
    assign b_err   = bus.b_valid & ~b_legal;

    for (genvar k = 0; k < NUM_IDS; k++) begin : g_q
        logic r_enq;
        logic b_enq;
        assign r_enq = bus.r_valid & r_ready & (bus.r_id == 4'(k));
        assign b_enq = bus.b_valid & b_ready & (bus.b_id == 4'(k));

        axi4_id_resp_demux_q #(.W(RW), .DEPTH(DEPTH)) u_rq (
            .clock     (clock),
            .reset_n   (reset_n),
            .enq       (r_enq),
            .enq_data  ({bus.r_last, bus.r_data}),
            .deq_ready (bus.r_deq_ready[k]),
            .deq_valid (bus.r_deq_valid[k]),
            .not_full  (r_q_rdy[k]),
            .deq_data  (bus.r_deq_data[k*RW +: RW])
        );

        axi4_id_resp_demux_q #(.W(2), .DEPTH(DEPTH)) u_bq (
            .clock     (clock),
            .reset_n   (reset_n),
            .enq       (b_enq),
            .enq_data  (bus.b_resp),
            .deq_ready (bus.b_deq_ready[k]),
            .deq_valid (bus.b_deq_valid[k]),
            .not_full  (b_q_rdy[k]),
            .deq_data  (bus.b_deq_resp[k*2 +: 2])
        );
    end

    // First error wins; a new error in the clear cycle is captured.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_valid <= 1'b0;
            err_chan  <= 1'b0;
            err_id    <= '0;
        end else if ((r_err || b_err) && (!err_valid || bus.err_clear)) begin
            err_valid <= 1'b1;
            err_chan  <= ~r_err;
            err_id    <= r_err ? bus.r_id : bus.b_id;
        end else if (bus.err_clear) begin
            err_valid <= 1'b0;
            err_chan  <= 1'b0;
            err_id    <= '0;
        end
    end

    assign bus.r_ready   = r_ready;
    assign bus.b_ready   = b_ready;
    assign bus.r_q_ready = r_q_rdy;
    assign bus.b_q_ready = b_q_rdy;
    assign bus.err_valid = err_valid;
    assign bus.err_chan  = err_chan;
    assign bus.err_id    = err_id;
endmodule

// File: tb/tb_axi4_id_resp_demux.sv
// Directed vector bench for axi4_id_resp_demux (NUM_IDS=2, DEPTH=2, DATA_W=64).
module tb_axi4_id_resp_demux;
    logic clock;
    logic reset_n;
    int   total;
    int   bad;

    axi4_id_resp_demux_if #(.NUM_IDS(2), .DATA_W(64)) bus ();

    axi4_id_resp_demux #(.NUM_IDS(2), .DEPTH(2), .DATA_W(64)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       rv;
        logic [3:0] rid;
        logic [7:0] rd;
        logic       rl;
        logic       bv;
        logic [3:0] bid;
        logic [1:0] bresp;
        logic [1:0] rdr;
        logic [1:0] bdr;
        logic       clr;
        logic       e_rr;
        logic       e_br;
        logic [1:0] e_rq;
        logic [1:0] e_bq;
        logic [1:0] e_rdv;
        logic [1:0] e_bdv;
        logic       e_ev;
        logic       e_ec;
        logic [3:0] e_eid;
        logic [8:0] e_rd0;
        logic [8:0] e_rd1;
        logic [1:0] e_bresp0;
    } vec_t;

    vec_t vecs[26];

    function automatic vec_t mk(
        input logic rv, input logic [3:0] rid, input logic [7:0] rd, input logic rl,
        input logic bv, input logic [3:0] bid, input logic [1:0] bresp,
        input logic [1:0] rdr, input logic [1:0] bdr, input logic clr,
        input logic e_rr, input logic e_br, input logic [1:0] e_rq, input logic [1:0] e_bq,
        input logic [1:0] e_rdv, input logic [1:0] e_bdv,
        input logic e_ev, input logic e_ec, input logic [3:0] e_eid,
        input logic [8:0] e_rd0, input logic [8:0] e_rd1, input logic [1:0] e_bresp0);
        vec_t v;
        v.rv = rv; v.rid = rid; v.rd = rd; v.rl = rl;
        v.bv = bv; v.bid = bid; v.bresp = bresp;
        v.rdr = rdr; v.bdr = bdr; v.clr = clr;
        v.e_rr = e_rr; v.e_br = e_br; v.e_rq = e_rq; v.e_bq = e_bq;
        v.e_rdv = e_rdv; v.e_bdv = e_bdv;
        v.e_ev = e_ev; v.e_ec = e_ec; v.e_eid = e_eid;
        v.e_rd0 = e_rd0; v.e_rd1 = e_rd1; v.e_bresp0 = e_bresp0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.r_valid     = 1'b0;
        bus.r_id        = 4'h0;
        bus.r_data      = '0;
        bus.r_last      = 1'b0;
        bus.b_valid     = 1'b0;
        bus.b_id        = 4'h0;
        bus.b_resp      = 2'b00;
        bus.r_deq_ready = 2'b00;
        bus.b_deq_ready = 2'b00;
        bus.err_clear   = 1'b0;
    endtask

    function automatic logic [64:0] rbeat(input logic [8:0] v);
        return {v[8], 56'h0, v[7:0]};
    endfunction

    initial begin
        logic [64:0] exp_head;
        total = 0;
        bad   = 0;
        idle_inputs();
        reset_n = 1'b0;

        //          rv rid  rd     rl bv bid   br     rdr    bdr    clr | rr br rq     bq     rdv    bdv    ev ec eid   rd0      rd1      bresp0
        vecs[0]  = mk(0, 4'h0, 8'h00, 0, 0, 4'h0, 2'd0, 2'b00, 2'b00, 0,  1, 1, 2'b11, 2'b11, 2'b00, 2'b00, 0, 0, 4'h0, 9'h000, 9'h000, 2'd0);
        vecs[1]  = mk(1, 4'h1, 8'hA5, 1, 0, 4'h0, 2'd0, 2'b00, 2'b00, 0,  1, 1, 2'b11, 2'b11, 2'b00, 2'b00, 0, 0, 4'h0, 9'h000, 9'h000, 2'd0);
        vecs[2]  = mk(0, 4'h0, 8'h00, 0, 0, 4'h0, 2'd0, 2'b00, 2'b00, 0,  1, 1, 2'b11, 2'b11, 2'b10, 2'b00, 0, 0, 4'h0, 9'h000, 9'h1A5, 2'd0);
        vecs[3]  = mk(1, 4'h0, 8'h11, 0, 0, 4'h0, 2'd0, 2'b00, 2'b00, 0,  1, 1, 2'b11, 2'b11, 2'b10, 2'b00, 0, 0, 4'h0, 9'h000, 9'h1A5, 2'd0);
        vecs[4]  = mk(1, 4'h0, 8'h22, 1, 0, 4'h0, 2'd0, 2'b00, 2'b00, 0,  1, 1, 2'b11, 2'b11, 2'b11, 2'b00, 0, 0, 4'h0, 9'h011, 9'h1A5, 2'd0);
        vecs[5]  = mk(1, 4'h0, 8'h33, 0, 0, 4'h0, 2'd0, 2'b00, 2'b00, 0,  0, 1, 2'b10, 2'b11, 2'b11, 2'b00, 0, 0, 4'h0, 9'h011, 9'h1A5, 2'd0);
        vecs[6]  = mk(1, 4'h1, 8'h44, 0, 0, 4'h0, 2'd0, 2'b00, 2'b00, 0,  1, 1, 2'b10, 2'b11, 2'b11, 2'b00, 0, 0, 4'h0, 9'h011, 9'h1A5, 2'd0);
        vecs[7]  = mk(1, 4'h0, 8'h33, 0, 0, 4'h0, 2'd0, 2'b01, 2'b00, 0,  0, 1, 2'b00, 2'b11, 2'b11, 2'b00, 0, 0, 4'h0, 9'h011, 9'h1A5, 2'd0);
        vecs[8]  = mk(1, 4'h0, 8'h33, 0, 0, 4'h0, 2'd0, 2'b00, 2'b00, 0,  1, 1, 2'b01, 2'b11, 2'b11, 2'b00, 0, 0, 4'h0, 9'h122, 9'h1A5, 2'd0);
        vecs[9]  = mk(0, 4'h0, 8'h00, 0, 0, 4'h0, 2'd0, 2'b11, 2'b00, 0,  0, 1, 2'b00, 2'b11, 2'b11, 2'b00, 0, 0, 4'h0, 9'h122, 9'h1A5, 2'd0);
        vecs[10] = mk(0, 4'h0, 8'h00, 0, 0, 4'h0, 2'd0, 2'b11, 2'b00, 0,  1, 1, 2'b11, 2'b11, 2'b11, 2'b00, 0, 0, 4'h0, 9'h033, 9'h044, 2'd0);
        vecs[11] = mk(0, 4'h0, 8'h00, 0, 0, 4'h0, 2'd0, 2'b00, 2'b00, 0,  1, 1, 2'b11, 2'b11, 2'b00, 2'b00, 0, 0, 4'h0, 9'h000, 9'h000, 2'd0);
        vecs[12] = mk(0, 4'h0, 8'h00, 0, 1, 4'h7, 2'd2, 2'b00, 2'b00, 0,  1, 1, 2'b11, 2'b11, 2'b00, 2'b00, 0, 0, 4'h0, 9'h000, 9'h000, 2'd0);
        vecs[13] = mk(0, 4'h0, 8'h00, 0, 1, 4'h1, 2'd3, 2'b00, 2'b00, 0,  1, 1, 2'b11, 2'b11, 2'b00, 2'b00, 1, 1, 4'h7, 9'h000, 9'h000, 2'd0);
        vecs[14] = mk(1, 4'hF, 8'h00, 0, 0, 4'h0, 2'd0, 2'b00, 2'b00, 0,  1, 1, 2'b11, 2'b11, 2'b00, 2'b10, 1, 1, 4'h7, 9'h000, 9'h000, 2'd0);
        vecs[15] = mk(0, 4'h0, 8'h00, 0, 0, 4'h0, 2'd0, 2'b00, 2'b10, 0,  1, 1, 2'b11, 2'b11, 2'b00, 2'b10, 1, 1, 4'h7, 9'h000, 9'h000, 2'd0);
        vecs[16] = mk(1, 4'h3, 8'h00, 0, 0, 4'h0, 2'd0, 2'b00, 2'b00, 1,  1, 1, 2'b11, 2'b11, 2'b00, 2'b00, 1, 1, 4'h7, 9'h000, 9'h000, 2'd0);
        vecs[17] = mk(0, 4'h0, 8'h00, 0, 0, 4'h0, 2'd0, 2'b00, 2'b00, 1,  1, 1, 2'b11, 2'b11, 2'b00, 2'b00, 1, 0, 4'h3, 9'h000, 9'h000, 2'd0);
        vecs[18] = mk(1, 4'h2, 8'h00, 0, 1, 4'h5, 2'd0, 2'b00, 2'b00, 0,  1, 1, 2'b11, 2'b11, 2'b00, 2'b00, 0, 0, 4'h0, 9'h000, 9'h000, 2'd0);
        vecs[19] = mk(0, 4'h0, 8'h00, 0, 0, 4'h0, 2'd0, 2'b00, 2'b00, 0,  1, 1, 2'b11, 2'b11, 2'b00, 2'b00, 1, 0, 4'h2, 9'h000, 9'h000, 2'd0);
        vecs[20] = mk(0, 4'h0, 8'h00, 0, 1, 4'h0, 2'd1, 2'b00, 2'b00, 1,  1, 1, 2'b11, 2'b11, 2'b00, 2'b00, 1, 0, 4'h2, 9'h000, 9'h000, 2'd0);
        vecs[21] = mk(0, 4'h0, 8'h00, 0, 1, 4'h0, 2'd2, 2'b00, 2'b00, 0,  1, 1, 2'b11, 2'b11, 2'b00, 2'b01, 0, 0, 4'h0, 9'h000, 9'h000, 2'd1);
        vecs[22] = mk(0, 4'h0, 8'h00, 0, 1, 4'h0, 2'd3, 2'b00, 2'b00, 0,  1, 0, 2'b11, 2'b10, 2'b00, 2'b01, 0, 0, 4'h0, 9'h000, 9'h000, 2'd1);
        vecs[23] = mk(0, 4'h0, 8'h00, 0, 0, 4'h0, 2'd0, 2'b00, 2'b01, 0,  1, 0, 2'b11, 2'b10, 2'b00, 2'b01, 0, 0, 4'h0, 9'h000, 9'h000, 2'd1);
        vecs[24] = mk(0, 4'h0, 8'h00, 0, 0, 4'h0, 2'd0, 2'b00, 2'b01, 0,  1, 1, 2'b11, 2'b11, 2'b00, 2'b01, 0, 0, 4'h0, 9'h000, 9'h000, 2'd2);
        vecs[25] = mk(0, 4'h0, 8'h00, 0, 0, 4'h0, 2'd0, 2'b00, 2'b00, 0,  1, 1, 2'b11, 2'b11, 2'b00, 2'b00, 0, 0, 4'h0, 9'h000, 9'h000, 2'd0);

        // Reset values while reset_n is held low
        #12;
        chk("rst_r_ready",   65'(bus.r_ready),   65'(1'b1));
        chk("rst_r_q_ready", 65'(bus.r_q_ready), 65'(2'b11));
        chk("rst_b_q_ready", 65'(bus.b_q_ready), 65'(2'b11));
        chk("rst_deq_valid", 65'({bus.r_deq_valid, bus.b_deq_valid}), 65'(4'b0000));
        chk("rst_err",       65'({bus.err_valid, bus.err_chan, bus.err_id}), 65'(6'h00));
        @(negedge clock);
        reset_n = 1'b1;

        // Table-driven cycle vectors
        for (int i = 0; i < 26; i++) begin
            @(negedge clock);
            bus.r_valid     = vecs[i].rv;
            bus.r_id        = vecs[i].rid;
            bus.r_data      = 64'(vecs[i].rd);
            bus.r_last      = vecs[i].rl;
            bus.b_valid     = vecs[i].bv;
            bus.b_id        = vecs[i].bid;
            bus.b_resp      = vecs[i].bresp;
            bus.r_deq_ready = vecs[i].rdr;
            bus.b_deq_ready = vecs[i].bdr;
            bus.err_clear   = vecs[i].clr;
            #2;
            chk($sformatf("v%0d_r_ready", i),     65'(bus.r_ready),     65'(vecs[i].e_rr));
            chk($sformatf("v%0d_b_ready", i),     65'(bus.b_ready),     65'(vecs[i].e_br));
            chk($sformatf("v%0d_r_q_ready", i),   65'(bus.r_q_ready),   65'(vecs[i].e_rq));
            chk($sformatf("v%0d_b_q_ready", i),   65'(bus.b_q_ready),   65'(vecs[i].e_bq));
            chk($sformatf("v%0d_r_deq_valid", i), 65'(bus.r_deq_valid), 65'(vecs[i].e_rdv));
            chk($sformatf("v%0d_b_deq_valid", i), 65'(bus.b_deq_valid), 65'(vecs[i].e_bdv));
            chk($sformatf("v%0d_err_valid", i),   65'(bus.err_valid),   65'(vecs[i].e_ev));
            if (vecs[i].e_ev) begin
                chk($sformatf("v%0d_err_chan", i), 65'(bus.err_chan), 65'(vecs[i].e_ec));
                chk($sformatf("v%0d_err_id", i),   65'(bus.err_id),   65'(vecs[i].e_eid));
            end
            if (vecs[i].e_rdv[0])
                chk($sformatf("v%0d_r_data0", i), bus.r_deq_data[64:0], rbeat(vecs[i].e_rd0));
            if (vecs[i].e_rdv[1])
                chk($sformatf("v%0d_r_data1", i), bus.r_deq_data[129:65], rbeat(vecs[i].e_rd1));
            if (vecs[i].e_bdv[0])
                chk($sformatf("v%0d_b_resp0", i), 65'(bus.b_deq_resp[1:0]), 65'(vecs[i].e_bresp0));
        end

        // Streaming 6 beats through ID1 with concurrent dequeue: order kept across pointer wrap
        for (int j = 0; j < 7; j++) begin
            @(negedge clock);
            idle_inputs();
            bus.r_valid     = (j < 6);
            bus.r_id        = 4'h1;
            bus.r_data      = 64'(32'h100 + j);
            bus.r_last      = (j == 5);
            bus.r_deq_ready = 2'b10;
            #2;
            chk($sformatf("s%0d_r_ready", j), 65'(bus.r_ready), 65'(1'b1));
            chk($sformatf("s%0d_r_deq_valid", j), 65'(bus.r_deq_valid), 65'((j == 0) ? 2'b00 : 2'b10));
            if (j > 0) begin
                exp_head = {(j == 6), 64'(32'h100 + j - 1)};
                chk($sformatf("s%0d_r_data1", j), bus.r_deq_data[129:65], exp_head);
            end
        end

        // Mid-stream reset with ID0 R and B queues both full
        for (int j = 0; j < 2; j++) begin
            @(negedge clock);
            idle_inputs();
            bus.r_valid = 1'b1;
            bus.r_data  = 64'(8'hC0 + j);
            bus.b_valid = 1'b1;
            bus.b_resp  = 2'(j + 1);
        end
        @(negedge clock);
        idle_inputs();
        #2;
        chk("pre_rst_r_q_ready", 65'(bus.r_q_ready), 65'(2'b10));
        chk("pre_rst_b_q_ready", 65'(bus.b_q_ready), 65'(2'b10));
        reset_n = 1'b0;
        #1;
        chk("mid_rst_deq_valid", 65'({bus.r_deq_valid, bus.b_deq_valid}), 65'(4'b0000));
        chk("mid_rst_q_ready",   65'({bus.r_q_ready, bus.b_q_ready}),     65'(4'b1111));
        chk("mid_rst_r_ready",   65'(bus.r_ready), 65'(1'b1));
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        bus.r_valid = 1'b1;
        bus.r_data  = 64'h77;
        bus.r_last  = 1'b0;
        #2;
        chk("post_rst_r_deq_valid0", 65'(bus.r_deq_valid), 65'(2'b00));
        @(negedge clock);
        idle_inputs();
        #2;
        chk("post_rst_r_deq_valid1", 65'(bus.r_deq_valid), 65'(2'b01));
        chk("post_rst_r_data0",      bus.r_deq_data[64:0], 65'h77);
        chk("post_rst_r_q_ready",    65'(bus.r_q_ready), 65'(2'b11));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
